// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared definitions for the FP decode queue: RISC-V FP major opcodes,
// OP-FP funct5 values, load/store width codes, and the 14-bit decoded
// control-signal struct carried with every queued instruction.
// No ports (package only).
package fpu_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  // OP-FP funct5 values (inst[31:27])
  localparam logic [4:0] F5_FADD     = 5'b00000;
  localparam logic [4:0] F5_FSUB     = 5'b00001;
  localparam logic [4:0] F5_FMUL     = 5'b00010;
  localparam logic [4:0] F5_FDIV     = 5'b00011;
  localparam logic [4:0] F5_FSGNJ    = 5'b00100;
  localparam logic [4:0] F5_FMINMAX  = 5'b00101;
  localparam logic [4:0] F5_FCVT_FF  = 5'b01000;
  localparam logic [4:0] F5_FSQRT    = 5'b01011;
  localparam logic [4:0] F5_FCMP     = 5'b10100;
  localparam logic [4:0] F5_FCVT_IF  = 5'b11000;
  localparam logic [4:0] F5_FCVT_FI  = 5'b11010;
  localparam logic [4:0] F5_FMV_XF   = 5'b11100;
  localparam logic [4:0] F5_FMV_FX   = 5'b11110;

  // Load/store width field (inst[14:12])
  localparam logic [2:0] WIDTH_W = 3'b010;
  localparam logic [2:0] WIDTH_D = 3'b011;

  // fmt field (inst[26:25])
  localparam logic [1:0] FMT_S = 2'b00;
  localparam logic [1:0] FMT_D = 2'b01;

  // Decoded controls, MSB first so the packed value matches io_out_sigs[13:0]
  typedef struct packed {
    logic wen;
    logic ren1;
    logic ren2;
    logic ren3;
    logic swap12;
    logic swap23;
    logic single_out;
    logic fromint;
    logic toint;
    logic fastpipe;
    logic fma;
    logic div;
    logic sqrt;
    logic wflags;
  } fpu_sigs_t;

  localparam int SIGS_W = $bits(fpu_sigs_t);

endpackage

// File: rtl/fpu_sig_decode.sv
// fpu_sig_decode
// Purely combinational decoder from a 32-bit instruction to the FP control
// struct plus an illegal flag. Illegal encodings always produce all-zero sigs.
// Parameters: SUPPORT_D - when 0, double-precision encodings are illegal.
// Ports:
//   inst    in  32  instruction word
//   sigs    out 14  decoded controls (fpu_sigs_t)
//   illegal out 1   instruction is not a supported FP encoding
module fpu_sig_decode
  import fpu_pkg::*;
#(
  parameter bit SUPPORT_D = 1'b1
) (
  input  logic [31:0] inst,
  output fpu_sigs_t   sigs,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [4:0] funct5;
  logic [1:0] fmt;
  logic [2:0] width;
  logic       fmt_ok;
  logic       width_ok;
  logic       known;
  logic       single;
  fpu_sigs_t  raw;
  logic       unused_bits;

  assign opcode = inst[6:0];
  assign funct5 = inst[31:27];
  assign fmt    = inst[26:25];
  assign width  = inst[14:12];

  // Register specifiers and rounding mode are not needed for control decode
  assign unused_bits = ^{inst[24:15], inst[11:7]};

  // fmt 10/11 are never supported; fmt 01 only with double support
  assign fmt_ok   = (fmt == FMT_S) || ((fmt == FMT_D) && SUPPORT_D);
  assign width_ok = (width == WIDTH_W) || ((width == WIDTH_D) && SUPPORT_D);

  // Build the raw controls for the recognised encoding, then apply the
  // single-precision output flag and zero everything if the encoding is
  // not legal in this configuration.
  always_comb begin
    raw    = '0;
    known  = 1'b0;
    single = (fmt == FMT_S);
    unique case (opcode)
      OPC_LOAD_FP: begin
        raw.wen = 1'b1;
        known   = width_ok;
        single  = (width == WIDTH_W);
      end
      OPC_STORE_FP: begin
        raw.ren2  = 1'b1;
        raw.toint = 1'b1;
        known     = width_ok;
        single    = (width == WIDTH_W);
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        raw.wen    = 1'b1;
        raw.ren1   = 1'b1;
        raw.ren2   = 1'b1;
        raw.ren3   = 1'b1;
        raw.fma    = 1'b1;
        raw.wflags = 1'b1;
        known      = fmt_ok;
      end
      OPC_OP_FP: begin
        known = fmt_ok;
        unique case (funct5)
          F5_FADD, F5_FSUB: begin
            // add/sub run on the FMA with the addend moved to slot 3
            raw.wen = 1'b1; raw.ren1 = 1'b1; raw.ren2 = 1'b1;
            raw.swap23 = 1'b1; raw.fma = 1'b1; raw.wflags = 1'b1;
          end
          F5_FMUL: begin
            raw.wen = 1'b1; raw.ren1 = 1'b1; raw.ren2 = 1'b1;
            raw.fma = 1'b1; raw.wflags = 1'b1;
          end
          F5_FDIV: begin
            raw.wen = 1'b1; raw.ren1 = 1'b1; raw.ren2 = 1'b1;
            raw.div = 1'b1; raw.wflags = 1'b1;
          end
          F5_FSQRT: begin
            raw.wen = 1'b1; raw.ren1 = 1'b1;
            raw.sqrt = 1'b1; raw.wflags = 1'b1;
          end
          F5_FSGNJ: begin
            raw.wen = 1'b1; raw.ren1 = 1'b1; raw.ren2 = 1'b1;
            raw.fastpipe = 1'b1;
          end
          F5_FMINMAX: begin
            raw.wen = 1'b1; raw.ren1 = 1'b1; raw.ren2 = 1'b1;
            raw.fastpipe = 1'b1; raw.wflags = 1'b1;
          end
          F5_FCVT_FF: begin
            raw.wen = 1'b1; raw.ren1 = 1'b1;
            raw.fastpipe = 1'b1; raw.wflags = 1'b1;
          end
          F5_FCMP: begin
            raw.ren1 = 1'b1; raw.ren2 = 1'b1;
            raw.toint = 1'b1; raw.wflags = 1'b1;
          end
          F5_FCVT_IF: begin
            raw.ren1 = 1'b1; raw.toint = 1'b1; raw.wflags = 1'b1;
          end
          F5_FCVT_FI: begin
            raw.wen = 1'b1; raw.fromint = 1'b1; raw.wflags = 1'b1;
          end
          F5_FMV_XF: begin
            raw.ren1 = 1'b1; raw.toint = 1'b1;
          end
          F5_FMV_FX: begin
            raw.wen = 1'b1; raw.fromint = 1'b1;
          end
          default: known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
    raw.single_out = raw.wen & single;
  end

  assign illegal = ~known;
  assign sigs    = known ? raw : '0;

endmodule

// File: rtl/fpu_decode_queue.sv
// fpu_decode_queue
// Circular FIFO of FP instructions. Each instruction is decoded as it is
// enqueued and its inst, tag, decoded sigs and illegal flag are stored
// together. Output appears one cycle after enqueue (no bypass); all data
// outputs read as zero while the queue is empty.
// Parameters: DEPTH (entries, >=2), SUPPORT_D (0 disables double), TAGW.
// Ports:
//   clock, reset                 clock / async active-high reset
//   io_in_valid/ready/inst/tag   enqueue handshake
//   io_out_valid/ready/inst/tag  dequeue handshake
//   io_out_sigs [13:0]           decoded controls of the head entry
//   io_out_illegal               head entry is not a supported FP encoding
//   io_flush                     discard all entries at the next edge
//   io_count                     current occupancy
module fpu_decode_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int SUPPORT_D = 1,
  parameter int TAGW      = 5,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [31:0]       io_in_inst,
  input  logic [TAGW-1:0]   io_in_tag,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [31:0]       io_out_inst,
  output logic [TAGW-1:0]   io_out_tag,
  output logic [SIGS_W-1:0] io_out_sigs,
  output logic              io_out_illegal,
  input  logic              io_flush,
  output logic [CW-1:0]     io_count
);

  logic [31:0]     inst_mem    [DEPTH];
  logic [TAGW-1:0] tag_mem     [DEPTH];
  fpu_sigs_t       sigs_mem    [DEPTH];
  logic            illegal_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  fpu_sigs_t dec_sigs;
  logic      dec_illegal;
  logic      do_enq;
  logic      do_deq;

  fpu_sig_decode #(
    .SUPPORT_D (SUPPORT_D != 0)
  ) u_decode (
    .inst    (io_in_inst),
    .sigs    (dec_sigs),
    .illegal (dec_illegal)
  );

  // Ready depends only on registered occupancy, so there is no path from
  // io_out_ready; a full queue refuses enqueue even when it is draining.
  assign io_in_ready  = (count < CW'(DEPTH));
  assign io_out_valid = (count != '0);
  assign do_enq       = io_in_valid & io_in_ready;
  assign do_deq       = io_out_valid & io_out_ready;
  assign io_count     = count;

  // Entry storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (do_enq && !io_flush) begin
      inst_mem[wr_ptr]    <= io_in_inst;
      tag_mem[wr_ptr]     <= io_in_tag;
      sigs_mem[wr_ptr]    <= dec_sigs;
      illegal_mem[wr_ptr] <= dec_illegal;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (io_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io_out_inst    = io_out_valid ? inst_mem[rd_ptr]    : '0;
  assign io_out_tag     = io_out_valid ? tag_mem[rd_ptr]     : '0;
  assign io_out_sigs    = io_out_valid ? sigs_mem[rd_ptr]    : '0;
  assign io_out_illegal = io_out_valid ? illegal_mem[rd_ptr] : 1'b0;

endmodule
